// File: rtl/neuron_core_256x256.sv
// Wishbone-mapped 256x256 integrate-and-fire neuron core: synapse rows, per-neuron
// parameters, 16-bit saturating potentials and a spike register, all updated on accept.
module neuron_core_256x256 (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o
);
    localparam int unsigned NUM_N   = 256;
    localparam int unsigned PRM_W   = 80;
    localparam int unsigned POT_W   = 16;
    localparam logic [31:0] CMD_NEW  = 32'h3000_C001;
    localparam logic [31:0] CMD_LAST = 32'h3000_C003;

    logic [NUM_N-1:0]        syn_mem [NUM_N];
    logic [PRM_W-1:0]        prm_mem [NUM_N];
    logic signed [POT_W-1:0] pot     [NUM_N];
    logic [NUM_N-1:0]        spikes;
    logic                    image_active;

    logic                    acc_c, syn_hit_c, prm_hit_c, spk_hit_c, cmd_new_c, cmd_last_c, pkt_c;
    logic [7:0]              row_c, nrn_c;
    logic [2:0]              seg_c, spk_k_c;
    logic [1:0]              poff_c;
    logic [31:0]             rd_data_c;
    logic signed [POT_W-1:0] pot_pkt_c [NUM_N];
    logic signed [POT_W-1:0] pot_lp_c  [NUM_N];
    logic [NUM_N-1:0]        fire_c;

    function automatic logic signed [15:0] sat_add(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        if (!s[16] && s[15])      sat_add = 16'sh7FFF;
        else if (s[16] && !s[15]) sat_add = 16'sh8000;
        else                      sat_add = s[15:0];
    endfunction

    // Exact address decode; memory-mapped words must be word aligned
    always_comb begin
        acc_c      = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
        syn_hit_c  = (wbs_adr_i[31:13] == 19'h18000)   && (wbs_adr_i[1:0] == 2'b00);
        prm_hit_c  = (wbs_adr_i[31:12] == 20'h30004)   && (wbs_adr_i[1:0] == 2'b00);
        spk_hit_c  = (wbs_adr_i[31:5]  == 27'h1800400) && (wbs_adr_i[1:0] == 2'b00);
        cmd_new_c  = (wbs_adr_i == CMD_NEW);
        cmd_last_c = (wbs_adr_i == CMD_LAST);
        row_c      = wbs_adr_i[12:5];
        seg_c      = wbs_adr_i[4:2];
        nrn_c      = wbs_adr_i[11:4];
        poff_c     = wbs_adr_i[3:2];
        spk_k_c    = wbs_adr_i[4:2];
        pkt_c      = syn_hit_c && !wbs_we_i && (wbs_adr_i[4:0] == 5'd0) && image_active;
    end

    always_comb begin
        rd_data_c = '0;
        if (syn_hit_c) begin
            rd_data_c = syn_mem[row_c][{seg_c, 5'd0} +: 32];
        end else if (prm_hit_c) begin
            case (poff_c)
                2'd0:    rd_data_c = prm_mem[nrn_c][31:0];
                2'd1:    rd_data_c = prm_mem[nrn_c][63:32];
                2'd2:    rd_data_c = {16'h0000, prm_mem[nrn_c][79:64]};
                default: rd_data_c = '0;
            endcase
        end else if (spk_hit_c) begin
            rd_data_c = spikes[{spk_k_c, 5'd0} +: 32];
        end
    end

    // Next potential for every neuron under a packet and under a last-packet command
    always_comb begin
        logic [7:0]              wt, leak, rpot;
        logic signed [POT_W-1:0] v, pthr, nthr, rext;
        fire_c = '0;
        for (int j = 0; j < NUM_N; j++) begin
            wt   = prm_mem[j][{wbs_adr_i[6:5], 3'b000} +: 8];
            leak = prm_mem[j][39:32];
            pthr = prm_mem[j][55:40];
            nthr = prm_mem[j][71:56];
            rpot = prm_mem[j][79:72];
            rext = {{8{rpot[7]}}, rpot};
            pot_pkt_c[j] = syn_mem[row_c][j] ? sat_add(pot[j], {{8{wt[7]}}, wt}) : pot[j];
            v = sat_add(pot[j], {{8{leak[7]}}, leak});
            if (v >= pthr) begin
                fire_c[j]   = 1'b1;
                pot_lp_c[j] = rext;
            end else if (v < nthr) begin
                pot_lp_c[j] = rext;
            end else begin
                pot_lp_c[j] = v;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbs_ack_o    <= 1'b0;
            wbs_dat_o    <= '0;
            image_active <= 1'b0;
            spikes       <= '0;
            for (int i = 0; i < NUM_N; i++) begin
                syn_mem[i] <= '0;
                prm_mem[i] <= '0;
                pot[i]     <= '0;
            end
        end else begin
            wbs_ack_o <= acc_c;
            wbs_dat_o <= (acc_c && !wbs_we_i) ? rd_data_c : '0;
            if (acc_c && wbs_we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (wbs_sel_i[b]) begin
                        if (syn_hit_c)
                            syn_mem[row_c][{seg_c, 5'd0} + 8'(8*b) +: 8] <= wbs_dat_i[8*b +: 8];
                        if (prm_hit_c && poff_c == 2'd0)
                            prm_mem[nrn_c][8*b +: 8] <= wbs_dat_i[8*b +: 8];
                        if (prm_hit_c && poff_c == 2'd1)
                            prm_mem[nrn_c][32 + 8*b +: 8] <= wbs_dat_i[8*b +: 8];
                        if (prm_hit_c && poff_c == 2'd2 && b < 2)
                            prm_mem[nrn_c][64 + 8*b +: 8] <= wbs_dat_i[8*b +: 8];
                        if (spk_hit_c && wbs_dat_i == 32'd0)
                            spikes[{spk_k_c, 5'd0} + 8'(8*b) +: 8] <= 8'h00;
                    end
                end
            end else if (acc_c) begin
                if (cmd_new_c) begin
                    image_active <= 1'b1;
                    spikes       <= '0;
                    for (int j = 0; j < NUM_N; j++) pot[j] <= '0;
                end else if (cmd_last_c) begin
                    image_active <= 1'b0;
                    spikes       <= spikes | fire_c;
                    for (int j = 0; j < NUM_N; j++) pot[j] <= pot_lp_c[j];
                end else if (pkt_c) begin
                    for (int j = 0; j < NUM_N; j++) pot[j] <= pot_pkt_c[j];
                end
            end
        end
    end
endmodule

// File: tb/tb_neuron_core_256x256.sv
// Bench for neuron_core_256x256: directed table, multi-cycle corner sequences and
// randomized traffic checked against an integer-arithmetic model of the core.
module tb_neuron_core_256x256;
    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic        ack;
    logic [31:0] dat_r;

    int n_vec = 0;
    int n_err = 0;

    localparam bit [31:0] SYN  = 32'h3000_0000;
    localparam bit [31:0] PRM  = 32'h3000_4000;
    localparam bit [31:0] SPK  = 32'h3000_8000;
    localparam bit [31:0] NEWI = 32'h3000_C001;
    localparam bit [31:0] LAST = 32'h3000_C003;

    neuron_core_256x256 dut (
        .clk(clk), .rst(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_w),
        .wbs_ack_o(ack), .wbs_dat_o(dat_r)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit [255:0] m_syn [256];
    bit [79:0]  m_prm [256];
    int         m_pot [256];
    bit [255:0] m_spk;
    bit         m_act;

    function automatic int clamp(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) begin
            m_syn[i] = '0; m_prm[i] = '0; m_pot[i] = 0;
        end
        m_spk = '0; m_act = 1'b0;
    endfunction

    function automatic bit [31:0] model_op(input bit w, input bit [31:0] a,
                                           input bit [31:0] d, input bit [3:0] s);
        bit [31:0] r = 0;
        int off;
        if (a >= SYN && a < SYN + 32'h2000 && a[1:0] == 2'b00) begin
            int row, seg;
            off = int'(a - SYN); row = off / 32; seg = (off % 32) / 4;
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) m_syn[row][seg*32 + b*8 +: 8] = d[b*8 +: 8];
            end else begin
                r = m_syn[row][seg*32 +: 32];
                if (off % 32 == 0 && m_act)
                    for (int j = 0; j < 256; j++)
                        if (m_syn[row][j]) begin
                            byte wt;
                            wt = m_prm[j][8*(row % 4) +: 8];
                            m_pot[j] = clamp(m_pot[j] + wt);
                        end
            end
        end else if (a >= PRM && a < PRM + 32'h1000 && a[1:0] == 2'b00) begin
            int n, wd;
            off = int'(a - PRM); n = off / 16; wd = (off % 16) / 4;
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (s[b] && (wd < 2 || (wd == 2 && b < 2)))
                        m_prm[n][wd*32 + b*8 +: 8] = d[b*8 +: 8];
            end else if (wd < 2) r = m_prm[n][wd*32 +: 32];
            else if (wd == 2) r = {16'h0, m_prm[n][79:64]};
        end else if (a >= SPK && a < SPK + 32 && a[1:0] == 2'b00) begin
            int k;
            k = int'(a - SPK) / 4;
            if (w) begin
                if (d == 0)
                    for (int b = 0; b < 4; b++) if (s[b]) m_spk[k*32 + b*8 +: 8] = 8'h00;
            end else r = m_spk[k*32 +: 32];
        end else if (a == NEWI && !w) begin
            for (int j = 0; j < 256; j++) m_pot[j] = 0;
            m_spk = '0; m_act = 1'b1;
        end else if (a == LAST && !w) begin
            for (int j = 0; j < 256; j++) begin
                byte lk, rp;
                shortint pt, nt;
                int v;
                lk = m_prm[j][39:32]; pt = m_prm[j][55:40];
                nt = m_prm[j][71:56]; rp = m_prm[j][79:72];
                v = clamp(m_pot[j] + lk);
                if (v >= pt) begin m_spk[j] = 1'b1; m_pot[j] = rp; end
                else if (v < nt) m_pot[j] = rp;
                else m_pot[j] = v;
            end
            m_act = 1'b0;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    task automatic xfer(input bit w, input bit [31:0] a, input bit [31:0] d,
                        input bit [3:0] s, output bit [31:0] rd);
        int lat = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        do begin
            @(posedge clk); #1; lat++;
        end while (!ack && lat < 8);
        rd = dat_r;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("ack_latency", 32'(lat), 32'd1);
        @(posedge clk); #1;
        check("ack_single_cycle", 32'(ack), 32'd0);
    endtask

    task automatic do_op(input bit w, input bit [31:0] a, input bit [31:0] d,
                         input bit [3:0] s, output bit [31:0] rd);
        bit [31:0] exp;
        xfer(w, a, d, s, rd);
        exp = model_op(w, a, d, s);
        if (!w) check($sformatf("rd_%08h", a), rd, exp);
    endtask

    typedef struct {
        bit        we;
        bit [31:0] adr;
        bit [31:0] dat;
        bit [3:0]  sel;
        bit [31:0] exp;
    } vec_t;
    vec_t tbl [16];

    initial begin
        bit [31:0] rd;
        rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_w = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_dat", dat_r, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Directed table: basic access semantics of every region
        tbl[0]  = '{1'b1, SYN + 32'hAC, 32'hA5A5_5A5A, 4'hF, 32'h0};
        tbl[1]  = '{1'b0, SYN + 32'hAC, 32'h0, 4'h0, 32'hA5A5_5A5A};
        tbl[2]  = '{1'b1, PRM + 32'h20, 32'h0403_0201, 4'hF, 32'h0};
        tbl[3]  = '{1'b1, PRM + 32'h24, 32'h0010_0000, 4'hF, 32'h0};
        tbl[4]  = '{1'b1, PRM + 32'h28, 32'h0000_0001, 4'hF, 32'h0};
        tbl[5]  = '{1'b1, PRM + 32'h2C, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[6]  = '{1'b0, PRM + 32'h20, 32'h0, 4'h0, 32'h0403_0201};
        tbl[7]  = '{1'b0, PRM + 32'h24, 32'h0, 4'h0, 32'h0010_0000};
        tbl[8]  = '{1'b0, PRM + 32'h28, 32'h0, 4'h0, 32'h0000_0001};
        tbl[9]  = '{1'b0, PRM + 32'h2C, 32'h0, 4'h0, 32'h0};
        tbl[10] = '{1'b1, SYN + 32'hA0, 32'h1122_3344, 4'h5, 32'h0};
        tbl[11] = '{1'b0, SYN + 32'hA0, 32'h0, 4'h0, 32'h0022_0044};
        tbl[12] = '{1'b1, 32'h3000_2000, 32'hFFFF_FFFF, 4'hF, 32'h0};
        tbl[13] = '{1'b0, 32'h3000_2000, 32'h0, 4'h0, 32'h0};
        tbl[14] = '{1'b0, SPK, 32'h0, 4'h0, 32'h0};
        tbl[15] = '{1'b0, NEWI, 32'h0, 4'h0, 32'h0};
        for (int i = 0; i < 16; i++) begin
            do_op(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd);
            if (!tbl[i].we) check($sformatf("tbl%0d", i), rd, tbl[i].exp);
        end

        // Neuron 0: w0=3, leak=0, pos_thr=5, neg_thr=-100, reset_pot=0; row 0 bit 0 set
        do_op(1, PRM + 0, 32'h0000_0003, 4'hF, rd);
        do_op(1, PRM + 4, 32'h9C00_0500, 4'hF, rd);
        do_op(1, PRM + 8, 32'h0000_00FF, 4'hF, rd);
        do_op(1, SYN, 32'h0000_0001, 4'hF, rd);

        // Two packets cross the threshold
        do_op(0, NEWI, 0, 0, rd);
        do_op(0, SYN, 0, 0, rd);
        check("pkt_data", rd, 32'h1);
        do_op(0, SYN, 0, 0, rd);
        do_op(0, LAST, 0, 0, rd);
        do_op(0, SPK, 0, 0, rd);
        check("fire_two_pkts", rd & 32'h1, 32'h1);
        do_op(1, SPK, 32'h0, 4'hF, rd);
        do_op(0, SPK, 0, 0, rd);
        check("spike_clear", rd, 32'h0);
        do_op(0, LAST, 0, 0, rd);
        do_op(0, SPK, 0, 0, rd);
        check("pot_reset_after_fire", rd & 32'h1, 32'h0);

        // One packet stays below threshold
        do_op(0, NEWI, 0, 0, rd);
        do_op(0, SYN, 0, 0, rd);
        do_op(0, LAST, 0, 0, rd);
        do_op(0, SPK, 0, 0, rd);
        check("one_pkt_no_fire", rd & 32'h1, 32'h0);

        // Packets while inactive (and a command write) must not integrate
        do_op(1, NEWI, 32'hFFFF_FFFF, 4'hF, rd);
        do_op(0, SYN, 0, 0, rd);
        do_op(0, SYN, 0, 0, rd);
        do_op(0, LAST, 0, 0, rd);
        do_op(0, SPK, 0, 0, rd);
        check("inactive_no_integrate", rd & 32'h1, 32'h0);

        // Non-zero addr[4:0] synapse read is not a packet
        do_op(0, NEWI, 0, 0, rd);
        do_op(0, SYN + 4, 0, 0, rd);
        do_op(0, SYN + 4, 0, 0, rd);
        do_op(0, LAST, 0, 0, rd);
        do_op(0, SPK, 0, 0, rd);
        check("unaligned_pkt_no_integrate", rd & 32'h1, 32'h0);

        // Positive saturation: neuron 1 w0=127, leak=+1, pos_thr=32767, neg_thr=-32768
        do_op(1, PRM + 32'h10, 32'h0000_007F, 4'hF, rd);
        do_op(1, PRM + 32'h14, 32'h007F_FF01, 4'hF, rd);
        do_op(1, PRM + 32'h18, 32'h0000_0080, 4'hF, rd);
        do_op(1, SYN, 32'h0000_0003, 4'h1, rd);
        do_op(0, NEWI, 0, 0, rd);
        for (int i = 0; i < 300; i++) do_op(0, SYN, 0, 0, rd);
        do_op(0, LAST, 0, 0, rd);
        do_op(0, SPK, 0, 0, rd);
        check("saturate_fire", (rd >> 1) & 32'h1, 32'h1);

        // Randomized traffic against the model
        for (int it = 0; it < 1500; it++) begin
            int k, r;
            bit [31:0] d;
            k = $urandom_range(0, 99);
            r = $urandom_range(0, 7);
            d = $urandom;
            if (k < 22)
                do_op(1, SYN + 32'(r*32 + $urandom_range(0, 7)*4), d, 4'($urandom), rd);
            else if (k < 37)
                do_op(1, PRM + 32'($urandom_range(0, 255)*16 + $urandom_range(0, 3)*4),
                      d, 4'($urandom), rd);
            else if (k < 52)
                do_op(0, SYN + 32'(r*32), 0, 0, rd);
            else if (k < 57) do_op(0, NEWI, 0, 0, rd);
            else if (k < 63) do_op(0, LAST, 0, 0, rd);
            else if (k < 75)
                do_op(0, SPK + 32'($urandom_range(0, 7)*4), 0, 0, rd);
            else if (k < 80)
                do_op(1, SPK + 32'($urandom_range(0, 7)*4),
                      ($urandom_range(0, 1) != 0) ? 32'h0 : d, 4'($urandom), rd);
            else if (k < 90)
                do_op(0, PRM + 32'($urandom_range(0, 255)*16 + $urandom_range(0, 3)*4),
                      0, 0, rd);
            else if (k < 95)
                do_op(0, SYN + 32'($urandom_range(0, 2047)*4), 0, 0, rd);
            else
                do_op($urandom_range(0, 1) != 0, 32'h3000_F000 + 32'($urandom_range(0, 15)*4),
                      d, 4'hF, rd);
        end
        for (int k = 0; k < 8; k++) do_op(0, SPK + 32'(k*4), 0, 0, rd);

        // Reset during a pending strobe aborts it and clears everything
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = SYN + 32'hAC; rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_pending_ack", 32'(ack), 32'd0);
        end
        @(negedge clk); cyc = 1'b0; stb = 1'b0;
        @(negedge clk); rst = 1'b0;
        model_reset();
        do_op(0, SYN + 32'hAC, 0, 0, rd);
        check("rst_syn", rd, 32'h0);
        do_op(0, PRM + 32'h20, 0, 0, rd);
        check("rst_prm", rd, 32'h0);
        do_op(0, SPK, 0, 0, rd);
        check("rst_spk", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
